// File: rtl/ahb2amm_if.sv
// ahb2amm_if: AHB-Lite slave side and Avalon-MM master side of the bridge
interface ahb2amm_if #(parameter int P_AW = 32);
   logic            ahb_hsel;
   logic [P_AW-1:0] ahb_haddr;
   logic [1:0]      ahb_htrans;
   logic [2:0]      ahb_hsize;
   logic            ahb_hwrite;
   logic [2:0]      ahb_hburst;
   logic            ahb_hready;
   logic [31:0]     ahb_hwdata;
   logic            ahb_hreadyout;
   logic            ahb_hresp;
   logic [31:0]     ahb_hrdata;
   logic [P_AW-1:0] amm_address;
   logic [3:0]      amm_byteenable;
   logic            amm_write;
   logic            amm_read;
   logic [31:0]     amm_writedata;
   logic            amm_waitrequest;
   logic [31:0]     amm_readdata;
   logic            amm_readdatavalid;
   // hburst is absent from the bridge view: every beat is an independent transfer
   modport slave (
      input  ahb_hsel, ahb_haddr, ahb_htrans, ahb_hsize, ahb_hwrite, ahb_hready, ahb_hwdata,
             amm_waitrequest, amm_readdata, amm_readdatavalid,
      output ahb_hreadyout, ahb_hresp, ahb_hrdata,
             amm_address, amm_byteenable, amm_write, amm_read, amm_writedata
   );
   modport master (
      output ahb_hsel, ahb_haddr, ahb_htrans, ahb_hsize, ahb_hwrite, ahb_hburst, ahb_hready, ahb_hwdata,
             amm_waitrequest, amm_readdata, amm_readdatavalid,
      input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
             amm_address, amm_byteenable, amm_write, amm_read, amm_writedata
   );
endinterface

// File: rtl/ahb2amm.sv
// ahb2amm: AHB-Lite slave to Avalon-MM master bridge, one Avalon transfer per AHB beat
module ahb2amm #(parameter int P_AW = 32) (
   input logic       aclk,
   input logic       areset,
   ahb2amm_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_DATA, ERR1, ERR2} state_t;
   state_t          state, state_nxt, acc_state;
   logic [P_AW-1:0] addr_q;
   logic [3:0]      be_q, be;
   logic            legal, accept, done;
   always_comb begin
      legal = (bus.ahb_hsize == 3'd0) |
              ((bus.ahb_hsize == 3'd1) & ~bus.ahb_haddr[0]) |
              ((bus.ahb_hsize == 3'd2) & (bus.ahb_haddr[1:0] == 2'b00));
      be = bus.ahb_hsize == 3'd0 ? 4'b0001 << bus.ahb_haddr[1:0] :
           bus.ahb_hsize == 3'd1 ? (bus.ahb_haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      acc_state = ~legal ? ERR1 : bus.ahb_hwrite ? WR : RD_CMD;
   end
   always_comb begin
      state_nxt      = state;
      done           = 1'b1;
      bus.ahb_hresp  = 1'b0;
      bus.ahb_hrdata = '0;
      bus.amm_write  = 1'b0;
      bus.amm_read   = 1'b0;
      case (state)
         WR: begin
            bus.amm_write = 1'b1;
            done          = ~bus.amm_waitrequest;
         end
         RD_CMD: begin
            bus.amm_read = 1'b1;
            done         = 1'b0;
            state_nxt    = bus.amm_waitrequest ? RD_CMD : RD_DATA;
         end
         RD_DATA: begin
            bus.ahb_hrdata = bus.amm_readdata;
            done           = bus.amm_readdatavalid;
         end
         ERR1: begin
            done          = 1'b0;
            bus.ahb_hresp = 1'b1;
            state_nxt     = ERR2;
         end
         ERR2: bus.ahb_hresp = 1'b1;
         default: ;
      endcase
      // a new address phase is only taken in the cycle the current data phase ends
      accept = bus.ahb_hsel & bus.ahb_htrans[1] & bus.ahb_hready & done;
      if (done) state_nxt = accept ? acc_state : IDLE;
      bus.ahb_hreadyout = done;
   end
   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         state  <= IDLE;
         addr_q <= '0;
         be_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept & legal) begin
            addr_q <= {bus.ahb_haddr[P_AW-1:2], 2'b00};
            be_q   <= be;
         end
      end
   assign bus.amm_address    = addr_q;
   assign bus.amm_byteenable = be_q;
   assign bus.amm_writedata  = bus.ahb_hwdata;
endmodule

// File: tb/tb_ahb2amm.sv
// tb_ahb2amm: randomized scoreboard bench for the AHB-Lite to Avalon-MM bridge
module tb_ahb2amm;
   typedef struct {logic [31:0] a; logic [3:0] be; logic w; logic [31:0] d;} amm_t;
   typedef struct {logic r; logic [31:0] d;} ahb_t;
   logic aclk, areset, hr_lo;
   int   checks = 0, errors = 0, cyc = 0;
   amm_t amm_q[$];
   ahb_t ahb_q[$];
   logic [31:0] rmem [logic [31:0]];
   logic [31:0] amem [logic [31:0]];
   int   wr_pct = 0, wr_k = 0, rd_lat = 0, stray_pct = 0;
   logic rd_pend = 0;
   int   rd_cnt = 0, run = 0;
   logic [31:0] rd_word;
   logic pend = 0, prev_rd = 0;
   int   dcnt = 0, last_lat = 0, rd_hi = 0, strobes = 0, last_wr_cyc = 0, rd_start = 0;

   ahb2amm_if #(.P_AW(32)) bus ();
   ahb2amm #(.P_AW(32)) dut (.aclk(aclk), .areset(areset), .bus(bus.slave));
   assign bus.ahb_hready = bus.ahb_hreadyout & ~hr_lo;

   initial aclk = 0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] init_w(input logic [31:0] w);
      return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction
   function automatic logic [31:0] rget(input logic [31:0] w);
      return rmem.exists(w) ? rmem[w] : init_w(w);
   endfunction
   function automatic logic [31:0] aget(input logic [31:0] w);
      return amem.exists(w) ? amem[w] : init_w(w);
   endfunction

   // reference: what an accepted AHB beat must produce on each side
   task automatic expect_beat(input logic [2:0] sz, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      int n = 1 << sz;
      int off = int'(a % 4);
      logic [3:0] be = '0;
      logic [31:0] w = a >> 2;
      logic [31:0] v;
      if (sz > 3'd2 || (a % n) != 0) begin
         ahb_q.push_back('{1'b1, 32'h0});
         return;
      end
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
      v = rget(w);
      if (wr) begin
         for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
         rmem[w] = v;
         amm_q.push_back('{a & ~32'h3, be, 1'b1, wd});
         ahb_q.push_back('{1'b0, 32'h0});
      end else begin
         amm_q.push_back('{a & ~32'h3, be, 1'b0, 32'h0});
         ahb_q.push_back('{1'b0, v});
      end
   endtask

   task automatic beat(input logic sel, input logic [1:0] tr, input logic [2:0] sz, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      bus.ahb_hsel   = sel;
      bus.ahb_htrans = tr;
      bus.ahb_hsize  = sz;
      bus.ahb_hwrite = wr;
      bus.ahb_haddr  = a;
      bus.ahb_hburst = 3'($urandom);
      do begin @(negedge aclk); n++; end while (!bus.ahb_hready && n < 100);
      if (n >= 100) chk("beat_hready_timeout", bus.ahb_hready, 1);
      @(posedge aclk);
      if (sel && tr[1]) expect_beat(sz, wr, a, wd);
      #1 bus.ahb_hwdata = wd;
   endtask

   task automatic idle(input int n);
      bus.ahb_hsel   = 0;
      bus.ahb_htrans = 2'b00;
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((pend || ahb_q.size() != 0) && n < 200) begin @(posedge aclk); n++; end
      chk("drain_ahb_q", ahb_q.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   // Avalon-MM slave: memory, random/forced waitrequest, variable read latency, stray valids
   initial begin : amm_slave
      logic do_w, do_r;
      logic [31:0] sa, sd, v;
      logic [3:0] sbe;
      bus.amm_waitrequest   = 0;
      bus.amm_readdatavalid = 0;
      bus.amm_readdata      = 0;
      forever begin
         @(negedge aclk);
         do_w = bus.amm_write & ~bus.amm_waitrequest;
         do_r = bus.amm_read & ~bus.amm_waitrequest;
         sa = bus.amm_address; sd = bus.amm_writedata; sbe = bus.amm_byteenable;
         @(posedge aclk);
         if (areset) begin
            rd_pend = 0;
            run = 0;
         end else begin
            if (do_w) begin
               v = aget(sa >> 2);
               for (int i = 0; i < 4; i++) if (sbe[i]) v[8*i +: 8] = sd[8*i +: 8];
               amem[sa >> 2] = v;
            end
            if (do_r) begin
               rd_pend = 1;
               rd_cnt  = rd_lat < 0 ? int'($urandom_range(0, 2)) : rd_lat;
               rd_word = aget(sa >> 2);
            end
            if (do_w || do_r) run = 0;
         end
         #1;
         if (rd_pend && rd_cnt == 0) begin
            bus.amm_readdatavalid = 1;
            bus.amm_readdata      = rd_word;
            rd_pend               = 0;
         end else begin
            if (rd_pend) rd_cnt--;
            bus.amm_readdatavalid = !rd_pend && !bus.amm_read && !areset && ($urandom_range(0, 99) < stray_pct);
            bus.amm_readdata      = $urandom;
         end
         bus.amm_waitrequest = (bus.amm_read | bus.amm_write) && (run < wr_k || $urandom_range(0, 99) < wr_pct);
         if (bus.amm_read | bus.amm_write) run++;
      end
   end

   // Avalon command monitor
   initial begin : amm_mon
      amm_t e;
      forever begin
         @(negedge aclk);
         if (!areset) begin
            if (bus.amm_write && bus.amm_read) chk("strobes_exclusive", 1, 0);
            if (bus.amm_read) rd_hi++;
            if (bus.amm_read || bus.amm_write) strobes++;
            if (bus.amm_write) last_wr_cyc = cyc;
            if (bus.amm_read && !prev_rd) rd_start = cyc;
            prev_rd = bus.amm_read;
            if ((bus.amm_read || bus.amm_write) && !bus.amm_waitrequest) begin
               if (amm_q.size() == 0) chk("unexpected_strobe", {bus.amm_write, bus.amm_read}, 0);
               else begin
                  e = amm_q.pop_front();
                  chk("amm_address", bus.amm_address, e.a);
                  chk("amm_byteenable", 32'(bus.amm_byteenable), 32'(e.be));
                  chk("amm_write", 32'(bus.amm_write), 32'(e.w));
                  if (e.w) chk("amm_writedata", bus.amm_writedata, e.d);
               end
            end
         end
      end
   end

   // AHB data-phase monitor
   initial begin : ahb_mon
      ahb_t e;
      forever begin
         @(negedge aclk);
         if (areset) pend = 0;
         else begin
            if (pend) begin
               dcnt++;
               if (ahb_q.size() == 0) begin
                  chk("ahb_q_underflow", ahb_q.size(), 1);
                  pend = 0;
               end else begin
                  chk("hresp", 32'(bus.ahb_hresp), 32'(ahb_q[0].r));
                  if (bus.ahb_hreadyout) begin
                     e = ahb_q.pop_front();
                     chk("hrdata", bus.ahb_hrdata, e.d);
                     last_lat = dcnt;
                     pend = 0;
                  end
               end
            end
            if (bus.ahb_hsel && bus.ahb_htrans[1] && bus.ahb_hready) begin
               pend = 1;
               dcnt = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int s0, r, off;
      logic [2:0] sz;
      logic [1:0] tr;
      logic [31:0] a;
      areset = 1; hr_lo = 0;
      bus.ahb_hsel = 0; bus.ahb_htrans = 0; bus.ahb_hsize = 0; bus.ahb_hwrite = 0;
      bus.ahb_haddr = 0; bus.ahb_hburst = 0; bus.ahb_hwdata = 0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_hreadyout", 32'(bus.ahb_hreadyout), 1);
      chk("rst_hresp", 32'(bus.ahb_hresp), 0);
      chk("rst_amm_read", 32'(bus.amm_read), 0);
      chk("rst_amm_write", 32'(bus.amm_write), 0);
      chk("rst_amm_address", bus.amm_address, 0);
      chk("rst_amm_byteenable", 32'(bus.amm_byteenable), 0);
      @(posedge aclk); #1 areset = 0;
      idle(2);
      // zero-wait word write
      beat(1, 2'b10, 3'd2, 1, 32'h100, 32'hDEADBEEF);
      idle(1); wait_quiet();
      chk("wr_latency", last_lat, 1);
      // byte read with two waitrequest cycles
      amem[32'h80] = 32'h5A000000; rmem[32'h80] = 32'h5A000000;
      wr_k = 2; rd_lat = 2; rd_hi = 0;
      beat(1, 2'b10, 3'd0, 0, 32'h203, 32'h0);
      idle(1); wait_quiet();
      chk("rd_strobe_cycles", rd_hi, 3);
      chk("rd_stall_latency", last_lat, 6);
      wr_k = 0; rd_lat = 0;
      // misaligned word then legal halfword
      s0 = strobes;
      beat(1, 2'b10, 3'd2, 1, 32'h102, 32'h11223344);
      idle(1); wait_quiet();
      chk("err_latency", last_lat, 2);
      chk("err_no_strobe", strobes, s0);
      beat(1, 2'b10, 3'd1, 1, 32'h106, 32'hCAFEF00D);
      idle(1); wait_quiet();
      // back-to-back write then read
      beat(1, 2'b10, 3'd2, 1, 32'h0, 32'h01234567);
      beat(1, 2'b10, 3'd2, 0, 32'h4, 32'h0);
      idle(1); wait_quiet();
      chk("b2b_rd_start", rd_start, last_wr_cyc + 1);
      chk("rd_min_latency", last_lat, 2);
      // filtered address phases
      for (int c = 0; c < 4; c++) begin
         s0 = strobes;
         bus.ahb_hsel = c != 0; bus.ahb_hwrite = 1; bus.ahb_hsize = 3'd2; bus.ahb_haddr = 32'h40;
         bus.ahb_htrans = c == 1 ? 2'b00 : c == 2 ? 2'b01 : 2'b10;
         hr_lo = c == 3;
         repeat (3) begin @(negedge aclk); chk("filter_hreadyout", 32'(bus.ahb_hreadyout), 1); end
         bus.ahb_htrans = 2'b00; hr_lo = 0;
         idle(2);
         chk("filter_strobes", strobes, s0);
      end
      // stray readdatavalid while idle
      stray_pct = 100;
      repeat (4) begin
         @(negedge aclk);
         chk("stray_hrdata", bus.ahb_hrdata, 0);
         chk("stray_hreadyout", 32'(bus.ahb_hreadyout), 1);
      end
      stray_pct = 0;
      idle(2);
      // reset while waiting for read data
      rd_lat = 6;
      beat(1, 2'b10, 3'd2, 0, 32'h40, 32'h0);
      idle(0);
      r = 0;
      while (!rd_pend && r < 50) begin @(negedge aclk); r++; end
      @(negedge aclk);
      chk("rd_data_waiting", 32'(bus.ahb_hreadyout), 0);
      #2 areset = 1;
      #1;
      chk("arst_amm_read", 32'(bus.amm_read), 0);
      chk("arst_hreadyout", 32'(bus.ahb_hreadyout), 1);
      chk("arst_hresp", 32'(bus.ahb_hresp), 0);
      amm_q.delete(); ahb_q.delete();
      repeat (2) @(posedge aclk);
      #1 areset = 0;
      rd_lat = 0;
      beat(1, 2'b10, 3'd2, 0, 32'h40, 32'h0);
      idle(1); wait_quiet();
      chk("post_rst_latency", last_lat, 2);
      // randomized traffic
      wr_pct = 30; rd_lat = -1; stray_pct = 10;
      for (int k = 0; k < 300; k++) begin
         r  = $urandom_range(0, 19);
         sz = r < 18 ? 3'(r % 3) : 3'(r - 15);
         off = sz == 3'd0 ? int'($urandom_range(0, 3)) :
               $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 3)) :
               sz == 3'd1 ? 2 * int'($urandom_range(0, 1)) : 0;
         a  = 32'($urandom_range(0, 15) * 4 + off);
         r  = $urandom_range(0, 9);
         tr = r == 0 ? 2'b00 : r == 1 ? 2'b01 : r < 5 ? 2'b11 : 2'b10;
         beat($urandom_range(0, 15) != 0, tr, sz, 1'($urandom), a, $urandom);
      end
      idle(1); wait_quiet();
      chk("final_amm_q", amm_q.size(), 0);
      chk("final_ahb_q", ahb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ahb2amm.md
# ahb2amm

AHB-Lite slave to Avalon-MM master bridge: the responder end of the AHB-Lite bus, carrying each AHB beat to an Avalon-MM slave as one Avalon transfer. It lets an AHB-Lite master (CPU, DMA) reach Avalon-MM peripherals. It converts HSIZE/HADDR into byte enables and Avalon read/write strobes. It stretches the AHB data phase with HREADYOUT until the Avalon side completes. Misaligned or oversized accesses get a two-cycle ERROR response and never reach Avalon.

## Interface
- P_AW, 32: address width on both sides.
- aclk  in  1  single clock for both interfaces.
- areset  in  1  asynchronous, active-high reset.
- ahb_hsel  in  1  slave select.
- ahb_haddr  in  P_AW  address-phase address.
- ahb_htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- ahb_hsize  in  3  000 byte, 001 halfword, 010 word; others illegal.
- ahb_hwrite  in  1  1 = write.
- ahb_hburst  in  3  ignored; every beat is an independent transfer.
- ahb_hready  in  1  bus-level HREADY (previous data phase done).
- ahb_hwdata  in  32  data-phase write data.
- ahb_hreadyout  out  1  data phase complete.
- ahb_hresp  out  1  0 OKAY, 1 ERROR.
- ahb_hrdata  out  32  read data.
- amm_address  out  P_AW  byte address, bits [1:0] forced 0.
- amm_byteenable  out  4  lane enables.
- amm_write  out  1  write strobe.
- amm_read  out  1  read strobe.
- amm_writedata  out  32  equal to ahb_hwdata at all times.
- amm_waitrequest  in  1  Avalon stall.
- amm_readdata  in  32  read data.
- amm_readdatavalid  in  1  read data valid (pipelined read; one outstanding read max).

## Operation
- Accept: an address phase is accepted when ahb_hsel & ahb_htrans[1] & ahb_hready. SEQ is handled as NONSEQ. IDLE and BUSY are accepted with no action.
- Legality check at accept:
  - hsize 000: any address is legal.
  - hsize 001: requires haddr[0]=0.
  - hsize 010: requires haddr[1:0]=00.
  - Any other hsize, or a misalignment, is illegal.
- Byte enables for legal accesses:
  - byte: 0001 shifted left by haddr[1:0].
  - halfword: 0011 if haddr[1]=0, else 1100.
  - word: 1111.
- At accept, address, byteenable and direction are registered.
- State machine:
  - IDLE: legal write → WR; legal read → RD_CMD; illegal → ERR1.
  - WR: amm_write=1. When ~amm_waitrequest: ahb_hreadyout=1 in that same cycle. A new accept in that cycle goes to its next state; otherwise → IDLE.
  - RD_CMD: amm_read=1, ahb_hreadyout=0. When ~amm_waitrequest → RD_DATA.
  - RD_DATA: amm_read=0. ahb_hrdata=amm_readdata and ahb_hreadyout=amm_readdatavalid. On readdatavalid the beat completes; a new accept in that cycle goes to its next state, else → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. An accept is allowed in ERR2.
- ahb_hreadyout=1 and hresp=0 in IDLE.
- amm_readdatavalid outside RD_DATA is ignored.
- amm_write/amm_read never both 1. Address, byteenable and strobes are held stable while amm_waitrequest=1.
- ahb_hrdata is 0 outside RD_DATA.

## Timing
- Reset values:
  - ahb_hreadyout=1, ahb_hresp=0.
  - amm_read=0, amm_write=0.
  - amm_address=0, amm_byteenable=0.
  - state IDLE.
- Reset asserted mid-transfer drops the strobes immediately (asynchronous). No completion is issued.
- Write, accept in cycle N:
  - amm_write high from N+1.
  - With no waitrequest, hreadyout=1 in N+1 (zero AHB wait states).
  - Each waitrequest cycle adds one wait state.
- Read, accept in cycle N:
  - amm_read high in N+1.
  - readdatavalid earliest in N+2 gives hreadyout=1 in N+2 (one wait state minimum).
- Back-to-back: the accept of beat K+1 coincides with the final cycle of beat K. Avalon strobes for K+1 start the next cycle with no idle gap.
- Error: accept in N → hresp=1/hreadyout=0 in N+1 → hresp=1/hreadyout=1 in N+2.

## Test plan
- Word write: haddr=0x100, hsize=010, hwdata=0xDEADBEEF, waitrequest=0 → amm_write=1, address=0x100, byteenable=1111, writedata=0xDEADBEEF in N+1; hreadyout=1 in N+1.
- Byte read with stall: haddr=0x203, hsize=000, waitrequest high 2 cycles, readdatavalid 3 cycles after accept-of-read with readdata=0x5A000000 → byteenable=1000, address=0x200, amm_read high 3 cycles, hrdata=0x5A000000 with hreadyout=1 exactly on the valid cycle.
- Misaligned: hsize=010 at haddr=0x102 → no Avalon strobe; hresp=1,hreadyout=0 then hresp=1,hreadyout=1; then a legal halfword write to 0x106 → byteenable=1100.
- Back-to-back: write 0x0 then read 0x4 as pipelined NONSEQ, zero waitrequest → amm_write in N+1, amm_read in N+2, no idle cycle between.
- Filtering: htrans=IDLE/BUSY, hsel=0, or hready=0 with htrans=NONSEQ → no strobes, hreadyout stays 1. A stray readdatavalid in IDLE is ignored.
- Reset mid-read: areset asserted during RD_DATA → amm_read=0, hreadyout=1 asynchronously. After release, a new read completes normally.
